// File: rtl/escape_iter_engine.sv
// escape_iter_engine: sequential escape-time engine for the Julia/Mandelbrot
// renderer. It accepts one complex point per handshake, then iterates
// z <- z^2 + c at one iteration per clock until |z|^2 > 4 or the iteration
// limit is reached. It returns the count, the escape flag, a pixel colour and
// the tag that came in with the point.
//
// Optional feature macro: JULIA_MODE_EN
//   defined   : i_Mode chooses Mandelbrot (0) or Julia (1).
//   undefined : Mandelbrot only. i_Mode, i_CRe and i_CIm are ignored.
//
// Ports
//   i_Clk, i_Reset        clock, synchronous active-high reset
//   i_Valid / o_Ready     input point handshake (o_Ready = engine idle)
//   i_Re, i_Im            pixel point, signed fixed point with FRAC fraction bits
//   i_CRe, i_CIm          Julia constant, same format
//   i_Mode                0 = Mandelbrot, 1 = Julia
//   i_Tag                 opaque pixel tag, returned on o_Tag
//   o_Valid / i_Ready     result handshake
//   o_Count               final iteration count
//   o_Escaped             1 = escaped before the limit
//   o_PXData              24-bit RGB pixel
//   o_Tag                 tag captured with the point
module escape_iter_engine #(
    parameter int unsigned WIDTH    = 18,
    parameter int unsigned FRAC     = 14,
    parameter int unsigned ITER_W   = 8,
    parameter int unsigned MAX_ITER = 255,
    parameter int unsigned TAG_W    = 15
) (
    input  logic                    i_Clk,
    input  logic                    i_Reset,
    input  logic                    i_Valid,
    output logic                    o_Ready,
    input  logic signed [WIDTH-1:0] i_Re,
    input  logic signed [WIDTH-1:0] i_Im,
    input  logic signed [WIDTH-1:0] i_CRe,
    input  logic signed [WIDTH-1:0] i_CIm,
    input  logic                    i_Mode,
    input  logic [TAG_W-1:0]        i_Tag,
    output logic                    o_Valid,
    input  logic                    i_Ready,
    output logic [ITER_W-1:0]       o_Count,
    output logic                    o_Escaped,
    output logic [23:0]             o_PXData,
    output logic [TAG_W-1:0]        o_Tag
);

    // Full product width, scaled-square width, and one guard bit for sums.
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned SW = PW - FRAC;
    localparam int unsigned EW = SW + 1;

    localparam logic signed [EW-1:0] ESC_LIM  = EW'(4 << FRAC);
    localparam logic [ITER_W-1:0]    ITER_MAX = ITER_W'(MAX_ITER);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic                     ready_q, valid_q;
    logic signed [WIDTH-1:0]  zr_q, zr_d, zi_q, zi_d;
    logic signed [WIDTH-1:0]  cr_q, cr_d, ci_q, ci_d;
    logic [ITER_W-1:0]        n_q, n_d;
    logic [TAG_W-1:0]         tag_q, tag_d;
    logic [ITER_W-1:0]        count_q, count_d;
    logic                     esc_q, esc_d;
    logic [23:0]              px_q, px_d;
    logic [TAG_W-1:0]         otag_q, otag_d;

    logic signed [PW-1:0]     p_rr, p_ii, p_ri;
    logic signed [SW-1:0]     sr, si, sx;
    logic signed [EW-1:0]     mag2, upd_re, upd_im;
    logic                     escape_c;

`ifndef JULIA_MODE_EN
    // In the Mandelbrot-only build these inputs have no function.
    logic unused_julia;
    assign unused_julia = ^{i_Mode, i_CRe, i_CIm};
`endif

    // Squares and cross term of the current z, scaled back by FRAC (floor).
    assign p_rr = PW'(zr_q) * PW'(zr_q);
    assign p_ii = PW'(zi_q) * PW'(zi_q);
    assign p_ri = PW'(zr_q) * PW'(zi_q);
    assign sr   = SW'(p_rr >>> FRAC);
    assign si   = SW'(p_ii >>> FRAC);
    assign sx   = SW'(p_ri >>> FRAC);

    // |z|^2 at full width; the guard bit keeps the sum from overflowing.
    assign mag2     = EW'(sr) + EW'(si);
    assign escape_c = (mag2 > ESC_LIM);

    // Next z before truncation; the cast to WIDTH below wraps.
    assign upd_re = EW'(sr) - EW'(si) + EW'(cr_q);
    assign upd_im = EW'(sx) + EW'(sx) + EW'(ci_q);

    // Next-state and next-register values.
    always_comb begin
        state_d = state_q;
        zr_d    = zr_q;
        zi_d    = zi_q;
        cr_d    = cr_q;
        ci_d    = ci_q;
        n_d     = n_q;
        tag_d   = tag_q;
        count_d = count_q;
        esc_d   = esc_q;
        px_d    = px_q;
        otag_d  = otag_q;

        case (state_q)
            S_IDLE: begin
                if (i_Valid && ready_q) begin
                    state_d = S_ITER;
                    n_d     = '0;
                    tag_d   = i_Tag;
`ifdef JULIA_MODE_EN
                    if (i_Mode) begin
                        zr_d = i_Re;
                        zi_d = i_Im;
                        cr_d = i_CRe;
                        ci_d = i_CIm;
                    end else begin
                        zr_d = '0;
                        zi_d = '0;
                        cr_d = i_Re;
                        ci_d = i_Im;
                    end
`else
                    zr_d = '0;
                    zi_d = '0;
                    cr_d = i_Re;
                    ci_d = i_Im;
`endif
                end
            end

            S_ITER: begin
                if (escape_c) begin
                    state_d = S_DONE;
                    count_d = n_q;
                    esc_d   = 1'b1;
                    px_d    = {8'h00, 8'h00, n_q[ITER_W-1 -: 8]};
                    otag_d  = tag_q;
                end else if (n_q == ITER_MAX) begin
                    state_d = S_DONE;
                    count_d = ITER_MAX;
                    esc_d   = 1'b0;
                    px_d    = 24'h0;
                    otag_d  = tag_q;
                end else begin
                    zr_d = WIDTH'(upd_re);
                    zi_d = WIDTH'(upd_im);
                    n_d  = n_q + ITER_W'(1);
                end
            end

            S_DONE: begin
                // Return to idle only; a point offered now is taken next cycle.
                if (i_Ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; handshake flags follow the next state.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            zr_q    <= '0;
            zi_q    <= '0;
            cr_q    <= '0;
            ci_q    <= '0;
            n_q     <= '0;
            tag_q   <= '0;
            count_q <= '0;
            esc_q   <= 1'b0;
            px_q    <= '0;
            otag_q  <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == S_IDLE);
            valid_q <= (state_d == S_DONE);
            zr_q    <= zr_d;
            zi_q    <= zi_d;
            cr_q    <= cr_d;
            ci_q    <= ci_d;
            n_q     <= n_d;
            tag_q   <= tag_d;
            count_q <= count_d;
            esc_q   <= esc_d;
            px_q    <= px_d;
            otag_q  <= otag_d;
        end
    end

    assign o_Ready   = ready_q;
    assign o_Valid   = valid_q;
    assign o_Count   = count_q;
    assign o_Escaped = esc_q;
    assign o_PXData  = px_q;
    assign o_Tag     = otag_q;

endmodule
